// File: rtl/poly_add_seq.sv
// Sequencer for c = a + b mod Q over N coefficients.
// Reads a/b in lock-step, reduces each pair in a single step, and writes the result RD_LAT+1 cycles later.
module poly_add_seq #(
    parameter int N      = 1024,
    parameter int AW     = 10,
    parameter int Q      = 12289,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   dia,
    input  logic [15:0]   dib,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   dout
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | one read per cycle, addresses 0..N-1
    // DRAIN | reads finished, waiting for the last write
    // FIN   | one-cycle done pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [15:0]   Q16       = 16'(Q);

    state_t state;
    state_t state_nx;

    logic [RD_LAT-1:0] vld_d;
    logic [AW-1:0]     addr_d [RD_LAT];

    logic        sum_carry;
    logic [15:0] sum_lo;
    logic        sum_ge_q;
    logic [15:0] red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // The last index is being written this cycle.
                if (wr_en && (wr_addr == LAST_ADDR)) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // N is a power of two, so the increment wraps N-1 -> 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (state == READ) begin
            rd_addr <= rd_addr + 1'b1;
        end else begin
            rd_addr <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                addr_d[k] <= '0;
            end
        end else begin
            vld_d[0]  <= rd_en;
            addr_d[0] <= rd_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_d[k]  <= vld_d[k-1];
                addr_d[k] <= addr_d[k-1];
            end
        end
    end

    // The 17-bit sum is split into carry and low word; subtracting Q in
    // 16 bits gives the same low word as the full-width subtraction.
    always_comb begin
        {sum_carry, sum_lo} = {1'b0, dia} + {1'b0, dib};
        sum_ge_q            = sum_carry | (sum_lo >= Q16);
        red                 = sum_ge_q ? (sum_lo - Q16) : sum_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            dout    <= '0;
        end else begin
            wr_en <= vld_d[RD_LAT-1];
            if (vld_d[RD_LAT-1]) begin
                wr_addr <= addr_d[RD_LAT-1];
                dout    <= red;
            end
        end
    end

endmodule
